iter_mul_unit: RTL and testbench



---
 rtl/iter_mul_unit.sv | 123 ++++++++++++
 tb/tb_iter_mul_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/iter_mul_unit.sv
// Iterative shift-add MUL/MLA unit: one multiplier bit per cycle, WIDTH-bit truncated result,
// with a single-cycle write-back request toward the register file.
//
// state  | meaning
// S_IDLE | waiting for start; result/flags hold last completion
// S_BUSY | iterating, WIDTH cycles
// S_DONE | one-cycle done/wr_en pulse
module iter_mul_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic              acc_en,
  input  logic [WIDTH-1:0]  acc_val,
  input  logic [ADDR_W-1:0] dst_dir,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_dir,
  output logic              flag_n,
  output logic              flag_z
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [ADDR_W-1:0] wr_dir_q, wr_dir_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic [WIDTH-1:0]  acc_sum;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    wr_dir_d = wr_dir_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = opA;
          mplier_d = opB;
          acc_d    = acc_en ? acc_val : '0;
          dst_d    = dst_dir;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration: publish the final sum directly so DONE sees it.
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = acc_sum;
          flag_n_d = acc_sum[WIDTH-1];
          flag_z_d = (acc_sum == '0);
          wr_dir_d = dst_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      wr_dir_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wr_dir_q <= wr_dir_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign wr_en  = (state_q == S_DONE);
  assign result = result_q;
  assign wr_dir = wr_dir_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Bench for iter_mul_unit: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored starts and reset mid-operation.
module tb_iter_mul_unit;

  logic        clk = 1'b0;
  logic        rst, start, acc_en;
  logic [31:0] opA, opB, acc_val;
  logic [4:0]  dst_dir;
  logic        busy, done, wr_en, flag_n, flag_z;
  logic [31:0] result;
  logic [4:0]  wr_dir;

  int tests = 0;
  int fails = 0;

  iter_mul_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB),
    .acc_en(acc_en), .acc_val(acc_val), .dst_dir(dst_dir),
    .busy(busy), .done(done), .result(result), .wr_en(wr_en),
    .wr_dir(wr_dir), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic        en;
    logic [31:0] c;
    logic [4:0]  d;
    logic [31:0] exp_res;
    logic        exp_n, exp_z;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_mla(input logic [31:0] a, input logic [31:0] b,
                                          input logic en, input logic [31:0] c);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + (en ? 64'(c) : 64'd0);
    return p[31:0];
  endfunction

  // Called at a negedge; returns at the negedge after the done cycle (first idle cycle).
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic [31:0] c, input logic [4:0] d,
                        input logic [31:0] er, input logic en_, input logic ez);
    int cyc, bcnt;
    opA = a; opB = b; acc_en = en; acc_val = c; dst_dir = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opA = $urandom; opB = $urandom; acc_en = 1'($urandom); acc_val = $urandom; dst_dir = 5'($urandom);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      cyc++;
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(cyc), 64'd32);
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'd32);
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " wr_dir"}, 64'(wr_dir), 64'(d));
    chk({nm, " flags_n_z_wren_busy"}, {60'd0, flag_n, flag_z, wr_en, busy}, {60'd0, en_, ez, 1'b1, 1'b0});
    @(negedge clk);
    chk({nm, " post_done_wren_busy"}, {61'd0, done, wr_en, busy}, 64'd0);
    chk({nm, " result_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    int bad, npulse;
    logic [31:0] a, b, c, e;
    logic en;
    logic [4:0] d;

    vecs[0] = '{32'd6, 32'd7, 1'b0, 32'd0, 5'd7, 32'd42, 1'b0, 1'b0};
    vecs[1] = '{32'd5, 32'd5, 1'b1, 32'd55, 5'd10, 32'd80, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 5'd3, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'd2, 1'b0, 32'd0, 5'd4, 32'd0, 1'b0, 1'b1};
    vecs[4] = '{32'd0, 32'd123, 1'b0, 32'd0, 5'd5, 32'd0, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd5, 5'd31, 32'd6, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFD, 32'd4, 1'b0, 32'd99, 5'd17, 32'hFFFF_FFF4, 1'b1, 1'b0};

    // Reset with start held high
    rst = 1'b1; start = 1'b1; opA = 32'd6; opB = 32'd7; acc_en = 1'b0; acc_val = 32'd0; dst_dir = 5'd7;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset busy_done_wren", {61'd0, busy, done, wr_en}, 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset wr_dir_flags", {57'd0, wr_dir, flag_n, flag_z}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset no_op_started", {62'd0, busy, done}, 64'd0);

    // Directed table (entries run back-to-back)
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].c, vecs[i].d,
             vecs[i].exp_res, vecs[i].exp_n, vecs[i].exp_z);

    // Random ops against the model, with random idle gaps
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; c = $urandom; en = 1'($urandom); d = 5'($urandom);
      if (i % 4 == 1) b = 32'd0;
      e = ref_mla(a, b, en, c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op($sformatf("rnd%0d", i), a, b, en, c, d, e, e[31], e == 32'd0);
    end

    // Ignored start: 3*4 -> dst 1, extra starts in cycles 5 (BUSY) and 33 (DONE)
    opA = 32'd3; opB = 32'd4; acc_en = 1'b0; acc_val = 32'd0; dst_dir = 5'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bad = 0; npulse = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy !== (n <= 32)) bad++;
      if (done) npulse++;
      if (done !== (n == 33)) bad++;
      if (n == 33) begin
        chk("ign result", 64'(result), 64'd12);
        chk("ign wr_dir", 64'(wr_dir), 64'd1);
      end
      start = (n == 5 || n == 33);
      opA = 32'd9; opB = 32'd9; dst_dir = 5'd2;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign single_pulse", 64'(npulse), 64'd1);
    chk("ign busy_done_profile_errors", 64'(bad), 64'd0);
    chk("ign result_hold", {27'd0, wr_dir, result}, {27'd0, 5'd1, 32'd12});

    // Reset mid-operation
    opA = 32'd6; opB = 32'd7; acc_en = 1'b0; dst_dir = 5'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid outputs_zero", {25'd0, busy, done, wr_en, wr_dir, flag_n, flag_z, result}, 64'd0);
    npulse = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || wr_en || busy) npulse++;
      @(negedge clk);
    end
    chk("rstmid no_activity", 64'(npulse), 64'd0);
    run_op("rstmid new_op", 32'd2, 32'd3, 1'b0, 32'd0, 5'd6, 32'd6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
